// File: rtl/zports_regs.sv
`default_nettype none
// ============================================================================
// Module   : zports_regs
// Purpose  : Control-register and interrupt block behind the ZX-bus port
//            decoder. Brings asynchronous Z80 port writes into the fclk
//            domain, holds the W5300 ROM-window mapping, produces timed reset
//            pulses for the W5300 and SL811 and merges their interrupts into
//            a single ZX-bus interrupt request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   fclk           in   system clock
//   rst_n          in   asynchronous active-low reset
//   ports_wrena    in   decoded register-space write enable (async)
//   ports_wrstb_n  in   Z80 write strobe, active low (async)
//   ports_addr     in   register address (async)
//   ports_wrdata   in   write data (async)
//   ports_rddata   out  read data for ports_addr (combinational)
//   rommap_win     out  16K window select (A15:14)
//   rommap_ena     out  mapping window enable
//   w5300_rst_n    out  W5300 reset, active low
//   sl811_rst_n    out  SL811 reset, active low
//   w5300_int_n    in   W5300 interrupt, active low (async)
//   sl811_int_n    in   SL811 interrupt, active low (async)
//   zint_n         out  ZX-bus interrupt request, active low, registered
// Register map
//   0 SL811 data port (writes ignored, reads 0xFF)
//   1 ROMMAP  bit7 ena, bits1:0 win
//   2 CTRL    wr bit0/bit1 start reset pulse; bits5:4 irq enables (s,w)
//             rd bit0/bit1 pulse busy; bits5:4 enables
//   3 STATUS  rd bit0/1 pending, bit4/5 raw irq level; wr 1 clears pending
// ============================================================================
module zports_regs #(
    parameter int RST_LEN = 256     // reset pulse length in fclk cycles, 1..1023
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       ports_wrena,
    input  logic       ports_wrstb_n,
    input  logic [1:0] ports_addr,
    input  logic [7:0] ports_wrdata,
    output logic [7:0] ports_rddata,
    output logic [1:0] rommap_win,
    output logic       rommap_ena,
    output logic       w5300_rst_n,
    output logic       sl811_rst_n,
    input  logic       w5300_int_n,
    input  logic       sl811_int_n,
    output logic       zint_n
);

    localparam logic [9:0] c_RST_LEN     = 10'(RST_LEN);
    localparam logic [0:0] c_IDLE        = 1'b0;
    localparam logic [0:0] c_PULSE       = 1'b1;
    localparam logic [1:0] c_ADDR_SLDATA = 2'd0;
    localparam logic [1:0] c_ADDR_ROMMAP = 2'd1;
    localparam logic [1:0] c_ADDR_CTRL   = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS = 2'd3;

    logic [3:0] r_stb_sh;
    logic       w_wr;
    logic       w_wr_rommap;
    logic       w_wr_ctrl;
    logic       w_wr_status;
    logic [1:0] w_start;
    logic [1:0] w_clr;
    logic [1:0] w_int_n;
    logic [1:0] w_busy;
    logic [1:0] w_pend;
    logic [1:0] w_raw;
    logic [1:0] r_ien;
    logic       r_rommap_ena;
    logic [1:0] r_rommap_win;
    logic       r_zint_n;
    logic       w_unused;

    // ------------------------------------------------------------------
    // Write strobe: stages 0..2 synchronize, stage 3 holds the previous
    // synchronized value so the falling edge commits on the 4th edge.
    // Address/data/enable are sampled raw; the bus holds them stable
    // while the strobe is low.
    // ------------------------------------------------------------------
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_sh <= 4'hF;
        end else begin
            r_stb_sh <= {r_stb_sh[2:0], ports_wrstb_n};
        end
    end

    assign w_wr        = r_stb_sh[3] & ~r_stb_sh[2] & ports_wrena;
    assign w_wr_rommap = w_wr && (ports_addr == c_ADDR_ROMMAP);
    assign w_wr_ctrl   = w_wr && (ports_addr == c_ADDR_CTRL);
    assign w_wr_status = w_wr && (ports_addr == c_ADDR_STATUS);

    // index 0 = W5300, index 1 = SL811
    assign w_start = {2{w_wr_ctrl}}   & ports_wrdata[1:0];
    assign w_clr   = {2{w_wr_status}} & ports_wrdata[1:0];
    assign w_int_n = {sl811_int_n, w5300_int_n};

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rommap_ena <= 1'b0;
            r_rommap_win <= 2'b00;
            r_ien        <= 2'b00;
        end else begin
            if (w_wr_rommap) begin
                r_rommap_ena <= ports_wrdata[7];
                r_rommap_win <= ports_wrdata[1:0];
            end
            if (w_wr_ctrl) begin
                r_ien <= ports_wrdata[5:4];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-device reset pulse generator and interrupt pending logic
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_dev
        logic [0:0] r_state;
        logic [9:0] r_cnt;
        logic [1:0] r_isync;
        logic       r_iprev;
        logic       r_pend;
        logic       w_fall;

        // Comes out of reset already in PULSE so the device is held in
        // reset for RST_LEN cycles after rst_n releases. A start request
        // in PULSE reloads the counter, stretching the pulse.
        always_ff @(posedge fclk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= c_PULSE;
                r_cnt   <= c_RST_LEN;
            end else if (w_start[gi]) begin
                r_state <= c_PULSE;
                r_cnt   <= c_RST_LEN;
            end else if (r_state == c_PULSE) begin
                if (r_cnt == 10'd1) begin
                    r_state <= c_IDLE;
                end
                r_cnt <= r_cnt - 10'd1;
            end
        end

        always_ff @(posedge fclk or negedge rst_n) begin
            if (!rst_n) begin
                r_isync <= 2'b11;
                r_iprev <= 1'b1;
            end else begin
                r_isync <= {r_isync[0], w_int_n[gi]};
                r_iprev <= r_isync[1];
            end
        end

        assign w_fall = r_iprev & ~r_isync[1];

        // A device held in reset cannot raise a meaningful interrupt, so
        // its flag is kept clear. A new edge beats a simultaneous clear.
        always_ff @(posedge fclk or negedge rst_n) begin
            if (!rst_n) begin
                r_pend <= 1'b0;
            end else if (r_state == c_PULSE) begin
                r_pend <= 1'b0;
            end else if (w_fall) begin
                r_pend <= 1'b1;
            end else if (w_clr[gi]) begin
                r_pend <= 1'b0;
            end
        end

        assign w_busy[gi] = (r_state == c_PULSE);
        assign w_pend[gi] = r_pend;
        assign w_raw[gi]  = ~r_isync[1];
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_zint_n <= 1'b1;
        end else begin
            r_zint_n <= ~|(w_pend & r_ien);
        end
    end

    always_comb begin
        ports_rddata = 8'h00;
        case (ports_addr)
            c_ADDR_SLDATA: ports_rddata = 8'hFF;
            c_ADDR_ROMMAP: ports_rddata = {r_rommap_ena, 5'b00000, r_rommap_win};
            c_ADDR_CTRL:   ports_rddata = {2'b00, r_ien, 2'b00, w_busy};
            c_ADDR_STATUS: ports_rddata = {2'b00, w_raw, 2'b00, w_pend};
            default:       ports_rddata = 8'h00;
        endcase
    end

    assign rommap_ena  = r_rommap_ena;
    assign rommap_win  = r_rommap_win;
    assign w5300_rst_n = ~w_busy[0];
    assign sl811_rst_n = ~w_busy[1];
    assign zint_n      = r_zint_n;

    // write-data bits with no register behind them
    assign w_unused = ^{ports_wrdata[6], ports_wrdata[3:2]};

endmodule

`default_nettype wire

// File: tb/tb_zports_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_zports_regs
// Purpose  : Self-checking bench for zports_regs. A reference model predicts
//            the visible outputs after every clock edge / reset event and
//            queues them; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zports_regs;

    localparam int L = 8;

    logic       fclk          = 1'b0;
    logic       rst_n         = 1'b0;
    logic       ports_wrena   = 1'b0;
    logic       ports_wrstb_n = 1'b1;
    logic [1:0] ports_addr    = 2'd1;
    logic [7:0] ports_wrdata  = 8'h00;
    logic       w5300_int_n   = 1'b1;
    logic       sl811_int_n   = 1'b1;
    logic [7:0] ports_rddata;
    logic [1:0] rommap_win;
    logic       rommap_ena;
    logic       w5300_rst_n;
    logic       sl811_rst_n;
    logic       zint_n;

    zports_regs #(.RST_LEN(L)) dut (
        .fclk          (fclk),
        .rst_n         (rst_n),
        .ports_wrena   (ports_wrena),
        .ports_wrstb_n (ports_wrstb_n),
        .ports_addr    (ports_addr),
        .ports_wrdata  (ports_wrdata),
        .ports_rddata  (ports_rddata),
        .rommap_win    (rommap_win),
        .rommap_ena    (rommap_ena),
        .w5300_rst_n   (w5300_rst_n),
        .sl811_rst_n   (sl811_rst_n),
        .w5300_int_n   (w5300_int_n),
        .sl811_int_n   (sl811_int_n),
        .zint_n        (zint_n)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        int         edge_no;
        logic       ena;
        logic [1:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic       w_rst_n;
        logic       s_rst_n;
        logic       ena;
        logic [1:0] win;
        logic       zint_n;
        logic [7:0] rd;
    } exp_t;

    wr_t  wq[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    logic [7:0] m_rommap;
    logic [1:0] m_ien;
    logic [1:0] m_pend;
    logic       m_zint_n;
    int         m_end[2];       // device output is low while cyc < m_end
    logic [3:0] m_hist[2];      // interrupt input sampled at the last 4 edges
    logic [1:0] m_fall, m_clr, m_start, m_busy_b, m_pend_o, m_ien_o;
    wr_t        m_w;
    exp_t       mon_e;

    function automatic exp_t snapshot();
        exp_t       e;
        logic [1:0] busy;
        logic [1:0] raw;
        for (int d = 0; d < 2; d++) begin
            busy[d] = (cyc < m_end[d]);
            raw[d]  = ~m_hist[d][1];
        end
        e.w_rst_n = ~busy[0];
        e.s_rst_n = ~busy[1];
        e.ena     = m_rommap[7];
        e.win     = m_rommap[1:0];
        e.zint_n  = m_zint_n;
        case (ports_addr)
            2'd0:    e.rd = 8'hFF;
            2'd1:    e.rd = m_rommap;
            2'd2:    e.rd = {2'b00, m_ien, 2'b00, busy};
            default: e.rd = {2'b00, raw, 2'b00, m_pend};
        endcase
        return e;
    endfunction

    // reference model
    initial forever begin
        @(posedge fclk or negedge rst_n);
        if (fclk) cyc++;
        if (!rst_n) begin
            m_rommap = 8'h00;
            m_ien    = 2'b00;
            m_pend   = 2'b00;
            m_zint_n = 1'b1;
            for (int d = 0; d < 2; d++) begin
                m_end[d]  = cyc + L;
                m_hist[d] = 4'hF;
            end
            wq.delete();
        end else begin
            m_pend_o  = m_pend;
            m_ien_o   = m_ien;
            m_hist[0] = {m_hist[0][2:0], w5300_int_n};
            m_hist[1] = {m_hist[1][2:0], sl811_int_n};
            m_clr     = 2'b00;
            m_start   = 2'b00;
            for (int d = 0; d < 2; d++) begin
                m_busy_b[d] = ((cyc - 1) < m_end[d]);
                // input high two edges before, low one edge after: edge
                // has crossed the synchronizer and sets the flag now
                m_fall[d]   = m_hist[d][3] & ~m_hist[d][2];
            end
            if (wq.size() > 0 && wq[0].edge_no == cyc) begin
                m_w = wq.pop_front();
                if (m_w.ena) begin
                    case (m_w.addr)
                        2'd1: m_rommap = m_w.data & 8'h83;
                        2'd2: begin
                            m_ien   = m_w.data[5:4];
                            m_start = m_w.data[1:0];
                        end
                        2'd3: m_clr = m_w.data[1:0];
                        default: ;
                    endcase
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (m_busy_b[d])    m_pend[d] = 1'b0;
                else if (m_fall[d]) m_pend[d] = 1'b1;
                else if (m_clr[d])  m_pend[d] = 1'b0;
                if (m_start[d]) m_end[d] = cyc + L;
            end
            m_zint_n = ~|(m_pend_o & m_ien_o);
        end
        sb.push_back(snapshot());
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h cycle=%0d addr=%0d",
                     nm, act, exp_v, cyc, ports_addr);
        end
    endtask

    // monitor
    initial forever begin
        @(posedge fclk or negedge rst_n);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 expected=1 cycle=%0d", cyc);
        end else begin
            mon_e = sb.pop_front();
            chk("w5300_rst_n", {7'd0, w5300_rst_n}, {7'd0, mon_e.w_rst_n});
            chk("sl811_rst_n", {7'd0, sl811_rst_n}, {7'd0, mon_e.s_rst_n});
            chk("rommap_ena",  {7'd0, rommap_ena},  {7'd0, mon_e.ena});
            chk("rommap_win",  {6'd0, rommap_win},  {6'd0, mon_e.win});
            chk("zint_n",      {7'd0, zint_n},      {7'd0, mon_e.zint_n});
            chk("rddata",      ports_rddata,        mon_e.rd);
        end
    end

    // port write: strobe low for 4 edges, commit expected on the 4th
    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic en);
        wr_t t;
        @(negedge fclk);
        ports_addr    = a;
        ports_wrdata  = d;
        ports_wrena   = en;
        ports_wrstb_n = 1'b0;
        t.edge_no = cyc + 4;
        t.ena     = en;
        t.addr    = a;
        t.data    = d;
        wq.push_back(t);
        repeat (4) @(negedge fclk);
        ports_wrstb_n = 1'b1;
        ports_wrena   = 1'b0;
    endtask

    task automatic look(input logic [1:0] a, input int n);
        @(negedge fclk);
        ports_addr = a;
        repeat (n) @(negedge fclk);
    endtask

    task automatic irq(input int d, input int lo);
        @(negedge fclk);
        if (d == 0) w5300_int_n = 1'b0;
        else        sl811_int_n = 1'b0;
        repeat (lo) @(negedge fclk);
        w5300_int_n = 1'b1;
        sl811_int_n = 1'b1;
    endtask

    initial begin
        // reset release
        repeat (3) @(negedge fclk);
        rst_n = 1'b1;
        look(2'd1, 4);
        look(2'd2, 5);
        look(2'd0, 4);

        // ROMMAP write, ignored writes
        wr(2'd1, 8'h82, 1'b1);
        look(2'd1, 3);
        wr(2'd0, 8'h55, 1'b1);
        look(2'd1, 2);
        wr(2'd1, 8'h03, 1'b0);
        look(2'd1, 2);

        // reset pulse restart mid-pulse
        wr(2'd2, 8'h01, 1'b1);
        wr(2'd2, 8'h01, 1'b1);
        look(2'd2, 16);

        // interrupt path, enabled then disabled
        wr(2'd2, 8'h10, 1'b1);
        irq(0, 2);
        look(2'd3, 6);
        wr(2'd3, 8'h01, 1'b1);
        look(2'd3, 3);
        wr(2'd2, 8'h00, 1'b1);
        irq(0, 2);
        look(2'd3, 6);
        wr(2'd3, 8'h01, 1'b1);

        // SL811 edge lands on the same edge as a STATUS clear
        wr(2'd2, 8'h30, 1'b1);
        fork
            wr(2'd3, 8'h02, 1'b1);
            begin
                repeat (2) @(negedge fclk);
                sl811_int_n = 1'b0;
                repeat (2) @(negedge fclk);
                sl811_int_n = 1'b1;
            end
        join
        look(2'd3, 4);
        wr(2'd3, 8'h03, 1'b1);
        look(2'd3, 3);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0, 1: wr(2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 4) != 0));
                2:    irq(int'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
                default: look(2'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
            endcase
        end
        look(2'd2, 12);

        // asynchronous reset during a W5300 pulse with an SL811 irq pending
        wr(2'd2, 8'h30, 1'b1);
        wr(2'd3, 8'h03, 1'b1);
        irq(1, 2);
        look(2'd3, 5);
        wr(2'd2, 8'h31, 1'b1);
        look(2'd2, 3);
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge fclk);
        rst_n = 1'b1;
        look(2'd2, L + 4);
        look(2'd1, 2);
        look(2'd3, 2);

        @(negedge fclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
